game_timer_ctrl: RTL
====================

Name: game_timer_ctrl

Overview:
- Sequences the countdown display timer for one game round.
- Converts debounced user controls (start, pause, abort) into timer reload, a one-second tick stream, pause/resume and end-of-game signalling.
- Sits between the board keys/50 MHz clock and the display timer: drives the timer's one_second_pulse and active-high reset, and consumes its game_finished.
- Keeps its own seconds_left for the warning output and game logic.

Parameters:
- CLK_HZ, 50000000, clock cycles per tick (benches override with a small value).
- GAME_SECONDS, 30, round length in seconds loaded on start.
- WARN_SECONDS, 5, warning asserted when seconds_left <= this value.
- CNT_W, 6, width of seconds_left (must hold GAME_SECONDS).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  debounced level, active-high
- pause  in  1  debounced level, active-high; each rising edge toggles pause/resume
- abort  in  1  debounced level, active-high
- game_finished  in  1  from display timer
- one_second_pulse  out  1  registered tick to display timer
- timer_rst  out  1  active-high reset/reload to display timer
- game_active  out  1  high in RUN or PAUSE
- paused  out  1  high in PAUSE
- game_over  out  1  high in DONE
- warning  out  1  (RUN or PAUSE) and seconds_left <= WARN_SECONDS
- seconds_left  out  CNT_W  remaining seconds

Behaviour:
- Reset (rst low, async):
  - State IDLE; prescaler = 0; seconds_left = GAME_SECONDS; edge-detect flops = 0.
  - one_second_pulse = 0, game_active = 0, paused = 0, game_over = 0, warning = 0, timer_rst = 1.
- Input conditioning:
  - Each control passes through a 2-flop synchroniser plus a previous-value flop.
  - rise = sync2 & ~prev, one cycle wide.
  - A held level produces exactly one rise.
  - The FSM acts on rise at the 3rd clk edge after the input rises.
- Priority within one cycle: abort > end condition > pause > tick.
- IDLE:
  - timer_rst = 1; game_finished ignored.
  - start rise -> LOAD.
- LOAD (exactly 1 cycle):
  - timer_rst = 1; seconds_left <= GAME_SECONDS; prescaler <= 0.
  - -> RUN.
- RUN:
  - timer_rst = 0; prescaler increments each cycle.
  - On prescaler == CLK_HZ-1: prescaler <= 0, pulse register set, seconds_left <= seconds_left-1 (saturates at 0).
  - one_second_pulse is high for exactly one cycle, the cycle after the wrap; seconds_left updates in that same cycle.
  - First pulse occurs CLK_HZ cycles after RUN entry; subsequent pulses every CLK_HZ cycles.
  - abort rise -> IDLE.
  - game_finished = 1 or seconds_left == 0 -> DONE.
  - pause rise -> PAUSE, prescaler held. A wrap in the same cycle still issues its tick.
  - start ignored.
- PAUSE:
  - prescaler and seconds_left frozen; no pulses; timer_rst = 0.
  - pause rise -> RUN, resuming from the held prescaler value.
  - abort rise -> IDLE.
  - start and game_finished ignored.
- DONE:
  - game_over = 1; no pulses; timer_rst = 0 (final display held).
  - start rise -> LOAD; abort rise -> IDLE.
- Boundary cases:
  - GAME_SECONDS = 0: LOAD -> RUN -> DONE with zero pulses.
  - Exactly GAME_SECONDS pulses are issued per uninterrupted round.
  - A reset mid-round returns to IDLE immediately, with no further pulse.
  - All outputs are registered or decoded from registered state only.

Decomposition:
- Package game_timer_pkg:
  - State encoding IDLE/LOAD/RUN/PAUSE/DONE (3-bit).
  - Default constants for CLK_HZ, GAME_SECONDS and WARN_SECONDS.
- Sub-module edge_sync: 2-flop synchroniser plus rising-edge pulse, same clk/rst. Instantiated three times (start, pause, abort).

Test Plan (CLK_HZ=10, GAME_SECONDS=5, WARN_SECONDS=2):
1. Release reset, raise start -> timer_rst high through LOAD then low; first pulse 10 cycles after RUN entry; pulses every 10 cycles; seconds_left 5,4,3,2,1,0; warning rises when seconds_left = 2; DONE after exactly 5 pulses; game_over = 1.
2. Pause when seconds_left = 3 and prescaler = 4, hold 40 cycles -> no pulses, seconds_left stays 3, paused = 1. Resume -> next pulse 6 cycles after RUN re-entry.
3. Abort during RUN -> IDLE, timer_rst = 1, game_active = 0, seconds_left = 5 after reset/LOAD; no further pulses.
4. Assert game_finished while seconds_left = 3 -> DONE next cycle, no further pulses. Then start -> LOAD, seconds_left = 5, round restarts.
5. Hold start high for 100 cycles -> exactly one LOAD. Raise pause and abort on the same cycle in RUN -> IDLE (abort wins).
6. Drive rst low between clock edges mid-RUN -> outputs and state clear immediately without a clock. After release, an IDLE start begins a fresh round.

Source files
------------

// File: rtl/game_timer_pkg.sv
// Shared types and default constants for the game round timer controller.
// Holds the FSM state encoding and the parameter defaults used by the top.
// No logic; imported by the controller and its sub-modules.
package game_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEF_CLK_HZ       = 50_000_000;
  localparam int DEF_GAME_SECONDS = 30;
  localparam int DEF_WARN_SECONDS = 5;
  localparam int DEF_CNT_W        = 6;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector for one key level.
// Latency: rise is high in the cycle after the 2nd clk edge that sees the level high.
// No backpressure: rise is a one-cycle strobe, a held level yields exactly one strobe.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  // Synchronise the asynchronous key level and keep its previous value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/game_timer_ctrl.sv
// Round sequencer: turns start/pause/abort keys into timer reload, 1 s ticks and end-of-game.
// Latency: key effects land on the 3rd clk edge after the key rises; all outputs registered.
// No backpressure: ticks are fire-and-forget pulses to the display timer.
module game_timer_ctrl
  import game_timer_pkg::*;
#(
  parameter int CLK_HZ       = DEF_CLK_HZ,
  parameter int GAME_SECONDS = DEF_GAME_SECONDS,
  parameter int WARN_SECONDS = DEF_WARN_SECONDS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             game_finished,
  output logic             one_second_pulse,
  output logic             timer_rst,
  output logic             game_active,
  output logic             paused,
  output logic             game_over,
  output logic             warning,
  output logic [CNT_W-1:0] seconds_left
);

  localparam int               PS_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] SEC_LOAD = CNT_W'(GAME_SECONDS);
  localparam logic [CNT_W-1:0] SEC_WARN = CNT_W'(WARN_SECONDS);

  logic start_rise;
  logic pause_rise;
  logic abort_rise;

  edge_sync u_start (.clk(clk), .rst(rst), .din(start), .rise(start_rise));
  edge_sync u_pause (.clk(clk), .rst(rst), .din(pause), .rise(pause_rise));
  edge_sync u_abort (.clk(clk), .rst(rst), .din(abort), .rise(abort_rise));

  state_t           state;
  state_t           state_nxt;
  logic [PS_W-1:0]  prescaler;
  logic [PS_W-1:0]  prescaler_nxt;
  logic [CNT_W-1:0] secs_nxt;
  logic             tick_nxt;
  logic             wrap;
  logic             active_nxt;

  assign wrap       = (prescaler == PS_LAST);
  assign active_nxt = (state_nxt == ST_RUN) || (state_nxt == ST_PAUSE);

  // Next state, prescaler and seconds; priority abort > end > pause > tick
  always_comb begin
    state_nxt     = state;
    prescaler_nxt = prescaler;
    secs_nxt      = seconds_left;
    tick_nxt      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_rise) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        state_nxt     = ST_RUN;
        prescaler_nxt = '0;
        secs_nxt      = SEC_LOAD;
      end
      ST_RUN: begin
        if (abort_rise) begin
          state_nxt = ST_IDLE;
        end else if (game_finished || (seconds_left == '0)) begin
          state_nxt = ST_DONE;
        end else begin
          if (pause_rise) state_nxt = ST_PAUSE;
          // A wrap coinciding with pause still delivers its tick
          if (wrap) begin
            prescaler_nxt = '0;
            tick_nxt      = 1'b1;
            if (seconds_left != '0) secs_nxt = seconds_left - CNT_W'(1);
          end else if (!pause_rise) begin
            prescaler_nxt = prescaler + PS_W'(1);
          end
        end
      end
      ST_PAUSE: begin
        if (abort_rise)      state_nxt = ST_IDLE;
        else if (pause_rise) state_nxt = ST_RUN;
      end
      ST_DONE: begin
        if (abort_rise)      state_nxt = ST_IDLE;
        else if (start_rise) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State registers with outputs registered from the next-state values
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_IDLE;
      prescaler        <= '0;
      seconds_left     <= SEC_LOAD;
      one_second_pulse <= 1'b0;
      timer_rst        <= 1'b1;
      game_active      <= 1'b0;
      paused           <= 1'b0;
      game_over        <= 1'b0;
      warning          <= 1'b0;
    end else begin
      state            <= state_nxt;
      prescaler        <= prescaler_nxt;
      seconds_left     <= secs_nxt;
      one_second_pulse <= tick_nxt;
      timer_rst        <= (state_nxt == ST_IDLE) || (state_nxt == ST_LOAD);
      game_active      <= active_nxt;
      paused           <= (state_nxt == ST_PAUSE);
      game_over        <= (state_nxt == ST_DONE);
      warning          <= active_nxt && (secs_nxt <= SEC_WARN);
    end
  end

endmodule
